// File: rtl/lc_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lc_bank_ctrl_if
//  Purpose  : CPU bus-cycle bundle seen by the language-card controller.
//  Signals  : bus_strobe - one-cycle pulse per CPU bus cycle
//             addr[15:0] - CPU address, valid while bus_strobe is high
//             we         - 1 = CPU write cycle
//  Modports : master (CPU bus decode side), slave (controller side)
//  Revision : 1.0 - initial release
// ============================================================================
interface lc_bank_ctrl_if;
    logic        bus_strobe;
    logic [15:0] addr;
    logic        we;

    modport master (output bus_strobe, output addr, output we);
    modport slave  (input  bus_strobe, input  addr, input  we);
endinterface : lc_bank_ctrl_if
`default_nettype wire

// File: rtl/lc_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lc_bank_ctrl
//  Purpose  : Language-card / Saturn bank-switched RAM controller. Decodes the
//             $C080+16*SLOT soft-switch block, tracks read-enable, bank-1 and
//             the two-access write-enable state, holds the 16K bank register
//             in Saturn mode, and maps $D000-$FFFF onto card RAM.
//  Ports    : mclk28       - system clock
//             reset_n      - asynchronous active-low reset
//             bus          - CPU bus bundle (slave modport)
//             card_addr    - {bank, offset[13:0]} card RAM address
//             card_sel     - current access is served by card RAM
//             card_ram_rd  - read-enable state
//             card_ram_we  - write-enable FSM is in WE
//             bank1        - $Dxxx bank 1 selected
//             bank_sel     - current 16K bank
//  Revision : 1.0 - initial release
// ============================================================================
module lc_bank_ctrl #(
    parameter int SLOT      = 0,
    parameter int MODE      = 0,
    parameter int BANK_BITS = 3
) (
    input  wire logic                   mclk28,
    input  wire logic                   reset_n,
    lc_bank_ctrl_if.slave               bus,
    output logic [BANK_BITS+13:0]       card_addr,
    output logic                        card_sel,
    output logic                        card_ram_rd,
    output logic                        card_ram_we,
    output logic                        bank1,
    output logic [BANK_BITS-1:0]        bank_sel
);

    // Write-enable FSM encoding
    localparam logic [1:0] ST_WP  = 2'd0;   // write protected
    localparam logic [1:0] ST_PRE = 2'd1;   // one odd read seen
    localparam logic [1:0] ST_WE  = 2'd2;   // write enabled

    localparam logic [11:0] SW_PAGE = 12'hC08 + 12'(SLOT);

    logic [1:0]           wr_state_q, wr_state_d;
    logic                 bank1_q,    bank1_d;
    logic                 read_en_q,  read_en_d;
    logic [BANK_BITS-1:0] bank_sel_q;

    logic       w_hit;
    logic [3:0] w_off;
    logic       w_bank_sw;
    logic       w_mode_hit;
    logic       w_dxxx;
    logic       w_def;
    logic [13:0] w_offset;

    assign w_off      = bus.addr[3:0];
    assign w_hit      = bus.bus_strobe && (bus.addr[15:4] == SW_PAGE);
    // In Saturn mode, offsets with bit 2 set select the 16K bank instead.
    assign w_bank_sw  = (MODE == 1) && w_off[2];
    assign w_mode_hit = w_hit && !w_bank_sw;

    always_comb begin
        wr_state_d = wr_state_q;
        bank1_d    = bank1_q;
        read_en_d  = read_en_q;
        if (w_mode_hit) begin
            bank1_d   = w_off[3];
            read_en_d = ~(w_off[0] ^ w_off[1]);
            if (!w_off[0]) begin
                wr_state_d = ST_WP;
            end else if (!bus.we) begin
                case (wr_state_q)
                    ST_WP:   wr_state_d = ST_PRE;
                    default: wr_state_d = ST_WE;
                endcase
            end else if (wr_state_q == ST_PRE) begin
                // A write between the two odd reads breaks the pair.
                wr_state_d = ST_WP;
            end
        end
    end

    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q <= ST_WE;
            bank1_q    <= 1'b0;
            read_en_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            bank1_q    <= bank1_d;
            read_en_q  <= read_en_d;
        end
    end

    generate
        if (MODE == 1) begin : g_saturn
            logic [2:0] w_bank_full;
            assign w_bank_full = {w_off[3], w_off[1], w_off[0]};
            always_ff @(posedge mclk28 or negedge reset_n) begin
                if (!reset_n) begin
                    bank_sel_q <= '0;
                end else if (w_hit && w_bank_sw) begin
                    bank_sel_q <= w_bank_full[BANK_BITS-1:0];
                end
            end
        end else begin : g_plain
            assign bank_sel_q = '0;
        end
    endgenerate

    // $Dxxx bank 1 folds onto offset $0xxx; bank 2 and $E000-$FFFF keep addr[13:12].
    assign w_dxxx   = (bus.addr[15:12] == 4'hD);
    assign w_offset = {bus.addr[13], bus.addr[12] & ~(bank1_q & w_dxxx), bus.addr[11:0]};
    assign w_def    = (bus.addr[15:14] == 2'b11) && (bus.addr[13:12] != 2'b00);

    assign card_addr   = {bank_sel_q, w_offset};
    assign card_ram_rd = read_en_q;
    assign card_ram_we = (wr_state_q == ST_WE);
    assign card_sel    = w_def && (bus.we ? card_ram_we : card_ram_rd);
    assign bank1       = bank1_q;
    assign bank_sel    = bank_sel_q;

endmodule : lc_bank_ctrl
`default_nettype wire

// File: tb/tb_lc_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc_bank_ctrl
//  Purpose  : Self-checking bench for lc_bank_ctrl. DUT 0 is a plain language
//             card in slot 0, DUT 1 a Saturn card (3 bank bits) in slot 5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lc_bank_ctrl;

    logic mclk28;
    logic reset_n;

    lc_bank_ctrl_if bus0 ();
    lc_bank_ctrl_if bus1 ();

    logic [16:0] card_addr0, card_addr1;
    logic        card_sel0, card_sel1;
    logic        rd0, rd1, we0, we1, b1_0, b1_1;
    logic [2:0]  bank0, bank1s;

    lc_bank_ctrl #(.SLOT(0), .MODE(0), .BANK_BITS(3)) u_dut0 (
        .mclk28      (mclk28),
        .reset_n     (reset_n),
        .bus         (bus0),
        .card_addr   (card_addr0),
        .card_sel    (card_sel0),
        .card_ram_rd (rd0),
        .card_ram_we (we0),
        .bank1       (b1_0),
        .bank_sel    (bank0)
    );

    lc_bank_ctrl #(.SLOT(5), .MODE(1), .BANK_BITS(3)) u_dut1 (
        .mclk28      (mclk28),
        .reset_n     (reset_n),
        .bus         (bus1),
        .card_addr   (card_addr1),
        .card_sel    (card_sel1),
        .card_ram_rd (rd1),
        .card_ram_we (we1),
        .bank1       (b1_1),
        .bank_sel    (bank1s)
    );

    initial mclk28 = 1'b0;
    always #5 mclk28 = ~mclk28;

    int errors = 0;
    int checks = 0;

    // Reference model: card parameters and abstract state per DUT.
    int m_slot [2] = '{0, 5};
    int m_mode [2] = '{0, 1};
    int m_reads[2];   // consecutive odd reads counted toward write-enable, capped at 2
    bit m_rd   [2];
    bit m_b1   [2];
    int m_bank [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_reads[d] = 2;
            m_rd[d]    = 1'b0;
            m_b1[d]    = 1'b0;
            m_bank[d]  = 0;
        end
    endfunction

    function automatic void model_access(input int d, input int a, input bit w);
        int off;
        if (a >= 'hC080 + 16*m_slot[d] && a <= 'hC08F + 16*m_slot[d]) begin
            off = a % 16;
            if (m_mode[d] == 1 && ((off / 4) % 2) == 1) begin
                m_bank[d] = (off / 8) * 4 + (off % 4);
            end else begin
                m_b1[d] = (off >= 8);
                m_rd[d] = ((off % 4) == 0) || ((off % 4) == 3);
                if ((off % 2) == 0)       m_reads[d] = 0;
                else if (!w)              m_reads[d] = (m_reads[d] >= 2) ? 2 : m_reads[d] + 1;
                else if (m_reads[d] == 1) m_reads[d] = 0;
            end
        end
    endfunction

    function automatic int exp_addr(input int d, input int a);
        int off;
        off = a % 16384;
        if (a >= 'hD000 && a < 'hE000 && m_b1[d]) off = off - 4096;
        return m_bank[d] * 16384 + off;
    endfunction

    function automatic bit exp_sel(input int d, input int a, input bit w);
        if (a < 'hD000) return 1'b0;
        return w ? (m_reads[d] == 2) : m_rd[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit s, input logic [15:0] a, input bit w);
        if (d == 0) begin
            bus0.bus_strobe = s; bus0.addr = a; bus0.we = w;
        end else begin
            bus1.bus_strobe = s; bus1.addr = a; bus1.we = w;
        end
    endtask

    // One bus cycle: strobe for one clock, then update the model.
    task automatic access(input int d, input logic [15:0] a, input bit w);
        @(negedge mclk28);
        drive(d, 1'b1, a, w);
        @(negedge mclk28);
        drive(d, 1'b0, a, w);
        model_access(d, int'(a), w);
    endtask

    task automatic chk_state(input int d, input string tag);
        if (d == 0) begin
            chk({tag, ".rd"},   {31'd0, rd0},  {31'd0, m_rd[0]});
            chk({tag, ".we"},   {31'd0, we0},  {31'd0, m_reads[0] == 2});
            chk({tag, ".b1"},   {31'd0, b1_0}, {31'd0, m_b1[0]});
            chk({tag, ".bank"}, {29'd0, bank0}, 32'(m_bank[0]));
        end else begin
            chk({tag, ".rd"},   {31'd0, rd1},  {31'd0, m_rd[1]});
            chk({tag, ".we"},   {31'd0, we1},  {31'd0, m_reads[1] == 2});
            chk({tag, ".b1"},   {31'd0, b1_1}, {31'd0, m_b1[1]});
            chk({tag, ".bank"}, {29'd0, bank1s}, 32'(m_bank[1]));
        end
    endtask

    // Present an address without a strobe and check the combinational map.
    task automatic chk_map(input int d, input logic [15:0] a, input bit w, input string tag);
        drive(d, 1'b0, a, w);
        #1;
        if (d == 0) begin
            chk({tag, ".addr"}, {15'd0, card_addr0}, 32'(exp_addr(0, int'(a))));
            chk({tag, ".sel"},  {31'd0, card_sel0},  {31'd0, exp_sel(0, int'(a), w)});
        end else begin
            chk({tag, ".addr"}, {15'd0, card_addr1}, 32'(exp_addr(1, int'(a))));
            chk({tag, ".sel"},  {31'd0, card_sel1},  {31'd0, exp_sel(1, int'(a), w)});
        end
    endtask

    initial begin
        drive(0, 1'b0, 16'h0000, 1'b0);
        drive(1, 1'b0, 16'h0000, 1'b0);
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge mclk28);
        reset_n = 1'b1;
        @(negedge mclk28);

        // Reset state and map
        chk_state(0, "reset0");
        chk_state(1, "reset1");
        chk_map(0, 16'hD123, 1'b0, "rst_rd_D123");
        chk("rst_rd_D123.lit", {31'd0, card_sel0}, 32'd0);
        chk_map(0, 16'hD123, 1'b1, "rst_wr_D123");
        chk("rst_wr_D123.lit", {15'd0, card_addr0}, 32'h01123);

        // Plain language card sequence
        access(0, 16'hC08B, 1'b0); chk_state(0, "C08B_first");
        chk("C08B_first.we_lit", {31'd0, we0}, 32'd1);
        access(0, 16'hC080, 1'b0); chk_state(0, "C080");
        access(0, 16'hC08B, 1'b0); chk_state(0, "C08B_pre");
        access(0, 16'hC08B, 1'b0); chk_state(0, "C08B_we");
        chk("C08B_we.lit", {30'd0, we0, b1_0}, 32'd3);
        chk_map(0, 16'hD000, 1'b1, "wr_D000_b1");

        // Write between odd reads breaks the pair
        access(0, 16'hC080, 1'b0);
        access(0, 16'hC081, 1'b0);
        access(0, 16'hC081, 1'b1);
        access(0, 16'hC081, 1'b0); chk_state(0, "broken_pair");
        chk("broken_pair.lit", {31'd0, we0}, 32'd0);
        access(0, 16'hC081, 1'b0); chk_state(0, "pair_done");

        // Idle clocks with a switch address but no strobe, then a single strobe
        access(0, 16'hC080, 1'b0);
        drive(0, 1'b0, 16'hC083, 1'b0);
        repeat (5) @(negedge mclk28);
        chk_state(0, "idle_no_strobe");
        access(0, 16'hC083, 1'b0); chk_state(0, "one_step");
        chk("one_step.lit", {31'd0, we0}, 32'd0);

        // Saturn card, slot 5
        access(1, 16'hC0D2, 1'b0); chk_state(1, "sat_wp");
        access(1, 16'hC0DF, 1'b0); chk_state(1, "sat_bank7");
        chk("sat_bank7.lit", {29'd0, bank1s}, 32'd7);
        access(1, 16'hC0D3, 1'b0); chk_state(1, "sat_pre");
        access(1, 16'hC0D3, 1'b0); chk_state(1, "sat_we");
        chk_map(1, 16'hF800, 1'b0, "sat_F800");
        chk("sat_F800.lit", {14'd0, card_sel1, card_addr1}, 32'h3F800);

        // Async reset while in PRE with bank 5
        access(1, 16'hC0DD, 1'b0);
        access(1, 16'hC0D2, 1'b0);
        access(1, 16'hC0D3, 1'b0); chk_state(1, "pre_bank5");
        @(posedge mclk28);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_state(1, "async_reset");
        @(negedge mclk28);
        reset_n = 1'b1;
        access(1, 16'hC0D3, 1'b0); chk_state(1, "post_reset_odd");

        // Randomised accesses against the model
        for (int i = 0; i < 300; i++) begin
            int d;
            logic [15:0] a;
            bit w;
            d = int'($urandom_range(0, 1));
            w = bit'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    a = 16'(16'hC080 + 16 * m_slot[d] + $urandom_range(0, 15));
                2:       a = 16'($urandom_range('hD000, 'hFFFF));
                default: a = 16'($urandom_range(0, 'hFFFF));
            endcase
            if (w && a[15:4] == 12'(12'hC08 + m_slot[d]) && $urandom_range(0, 1) == 1) w = 1'b0;
            access(d, a, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge mclk28);
            chk_state(d, "rand");
            chk_map(d, 16'($urandom_range('hC000, 'hFFFF)), bit'($urandom_range(0, 1)), "rand_map");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lc_bank_ctrl
`default_nettype wire
